// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - single-port BRAM arbiter: core has absolute priority, host is served in idle cycles
// Host read responses are tracked by a tag shift register matching the BRAM read latency.
module bram_port_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DWIDTH       = 32,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 16,
    localparam int NB_COL      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_en,
    input  logic [NB_COL-1:0]     core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DWIDTH-1:0]     core_wdata,
    output logic [DWIDTH-1:0]     core_rdata,
    input  logic                  host_req_valid,
    output logic                  host_req_ready,
    input  logic [NB_COL-1:0]     host_req_we,
    input  logic [ADDR_WIDTH-1:0] host_req_addr,
    input  logic [DWIDTH-1:0]     host_req_wdata,
    output logic                  host_rsp_valid,
    output logic [DWIDTH-1:0]     host_rsp_rdata,
    output logic                  host_starved,
    output logic                  mem_en,
    output logic [NB_COL-1:0]     mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0]     mem_wdata,
    input  logic [DWIDTH-1:0]     mem_rdata
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic                    w_accept;
    logic                    w_host_rd;
    logic [7:0]              w_wait_nxt;
    logic [7:0]              r_wait;
    logic                    r_starved;
    logic [READ_LATENCY-1:0] r_tag;

    // Ready is a pure function of core_en so the host never sees a combinational loop through valid.
    assign host_req_ready = ~core_en;
    assign w_accept       = host_req_valid & ~core_en;
    assign w_host_rd      = w_accept & (host_req_we == '0);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = host_req_addr;
        mem_wdata = host_req_wdata;
        if (core_en) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (host_req_valid) begin
            mem_en = 1'b1;
            mem_we = host_req_we;
        end
    end

    assign core_rdata     = mem_rdata;
    assign host_rsp_rdata = mem_rdata;
    assign host_rsp_valid = r_tag[READ_LATENCY-1];

    generate
        if (READ_LATENCY == 1) begin : g_tag1
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_tag <= '0;
                else       r_tag <= w_host_rd;
            end
        end else begin : g_tagn
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_tag <= '0;
                else       r_tag <= {r_tag[READ_LATENCY-2:0], w_host_rd};
            end
        end
    endgenerate

    always_comb begin
        w_wait_nxt = 8'd0;
        if (host_req_valid && core_en)
            w_wait_nxt = (r_wait == 8'hFF) ? r_wait : r_wait + 8'd1;
    end

    // Starved flag compares the counter's next value so it lines up with the cycle the count is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait    <= 8'd0;
            r_starved <= 1'b0;
        end else begin
            r_wait    <= w_wait_nxt;
            r_starved <= (w_wait_nxt >= LIMIT);
        end
    end

    assign host_starved = r_starved;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - scoreboard bench for bram_port_arbiter with a 2-cycle BRAM model
module tb_bram_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int SL = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          core_en = 1'b0;
    logic [3:0]    core_we = '0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic [DW-1:0] core_rdata;
    logic          host_req_valid = 1'b0;
    logic          host_req_ready;
    logic [3:0]    host_req_we = '0;
    logic [AW-1:0] host_req_addr = '0;
    logic [DW-1:0] host_req_wdata = '0;
    logic          host_rsp_valid;
    logic [DW-1:0] host_rsp_rdata;
    logic          host_starved;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    bram_port_arbiter #(
        .ADDR_WIDTH(AW), .DWIDTH(DW), .READ_LATENCY(RL), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .core_en(core_en), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_we(host_req_we), .host_req_addr(host_req_addr),
        .host_req_wdata(host_req_wdata), .host_rsp_valid(host_rsp_valid),
        .host_rsp_rdata(host_rsp_rdata), .host_starved(host_starved),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: byte writes, read-first, two-cycle read pipeline, plus a preload port.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd0, rd1;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            rd0 <= mem[mem_addr];
        end
        rd1 <= rd0;
    end
    assign mem_rdata = rd1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (host_rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got %h expected no response (cycle %0d)", host_rsp_rdata, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_data", 64'(host_rsp_rdata), 64'(mon_e.data));
                chk("rsp_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    task automatic drive(input logic ce, input logic [3:0] cwe, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cwd, input logic hv, input logic [3:0] hwe,
                         input logic [AW-1:0] ha, input logic [DW-1:0] hwd,
                         input logic [DW-1:0] exp_rd);
        @(posedge clk);
        #1;
        core_en = ce; core_we = cwe; core_addr = ca; core_wdata = cwd;
        host_req_valid = hv; host_req_we = hwe; host_req_addr = ha; host_req_wdata = hwd;
        if (!ce && hv && hwe == 4'h0) sb.push_back('{data: exp_rd, due: cyc + RL});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 4'h0, '0, '0, 0, 4'h0, '0, '0, '0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    initial begin
        preload(10'h005, 32'hDEADBEEF);
        preload(10'h001, 32'h11111111);
        preload(10'h002, 32'h22222222);
        preload(10'h003, 32'h33333333);
        preload(10'h020, 32'hAAAAAAAA);
        preload(10'h010, 32'h0F0F0F0F);

        // Reset state and combinational passthrough during reset
        @(negedge clk);
        chk("rst_rsp_valid", 64'(host_rsp_valid), 64'd0);
        chk("rst_starved", 64'(host_starved), 64'd0);
        chk("rst_ready", 64'(host_req_ready), 64'd1);
        chk("rst_mem_en_idle", 64'(mem_en), 64'd0);
        core_en = 1'b1; core_addr = 10'h0AB;
        #1;
        chk("rst_mem_addr_core", 64'(mem_addr), 64'h0AB);
        chk("rst_ready_core", 64'(host_req_ready), 64'd0);
        core_en = 1'b0; core_addr = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Single host read, latency 2
        drive(0, 4'h0, '0, '0, 1, 4'h0, 10'h005, '0, 32'hDEADBEEF);
        @(negedge clk);
        chk("hrd_mem_en", 64'(mem_en), 64'd1);
        chk("hrd_mem_addr", 64'(mem_addr), 64'h005);
        idle(3);

        // Core and host collide: core wins, host accepted next idle cycle
        drive(1, 4'h0, 10'h010, '0, 1, 4'h0, 10'h005, '0, 32'hDEADBEEF);
        @(negedge clk);
        chk("col_mem_addr", 64'(mem_addr), 64'h010);
        chk("col_ready", 64'(host_req_ready), 64'd0);
        drive(0, 4'h0, '0, '0, 1, 4'h0, 10'h005, '0, 32'hDEADBEEF);
        @(negedge clk);
        chk("col_ready_free", 64'(host_req_ready), 64'd1);
        chk("col_mem_addr_host", 64'(mem_addr), 64'h005);
        idle(3);

        // Back-to-back reads
        drive(0, 4'h0, '0, '0, 1, 4'h0, 10'h001, '0, 32'h11111111);
        drive(0, 4'h0, '0, '0, 1, 4'h0, 10'h002, '0, 32'h22222222);
        drive(0, 4'h0, '0, '0, 1, 4'h0, 10'h003, '0, 32'h33333333);
        idle(4);

        // Host byte write, then read back merged word
        drive(0, 4'h0, '0, '0, 1, 4'b0011, 10'h020, 32'h12345678, '0);
        @(negedge clk);
        chk("hwr_mem_we", 64'(mem_we), 64'h3);
        chk("hwr_mem_wdata", 64'(mem_wdata), 64'h12345678);
        drive(0, 4'h0, '0, '0, 1, 4'h0, 10'h020, '0, 32'hAAAA5678);
        idle(3);

        // Core write then host read of same word
        drive(1, 4'hF, 10'h030, 32'hCAFEF00D, 0, 4'h0, '0, '0, '0);
        @(negedge clk);
        chk("cwr_mem_we", 64'(mem_we), 64'hF);
        chk("cwr_mem_wdata", 64'(mem_wdata), 64'hCAFEF00D);
        drive(0, 4'h0, '0, '0, 1, 4'h0, 10'h030, '0, 32'hCAFEF00D);
        idle(3);

        // Invalid host request must not write
        drive(0, 4'h0, '0, '0, 0, 4'hF, 10'h020, 32'hFFFFFFFF, '0);
        @(negedge clk);
        chk("nov_mem_en", 64'(mem_en), 64'd0);
        chk("nov_mem_we", 64'(mem_we), 64'd0);
        idle(2);

        // Starvation: 20 core cycles, host address wanders while waiting
        for (int k = 1; k <= 20; k++) begin
            drive(1, 4'h0, 10'h010, '0, 1, 4'h0, AW'(k), '0, '0);
            @(negedge clk);
            chk($sformatf("starve_c%0d", k), 64'(host_starved), (k >= 17) ? 64'd1 : 64'd0);
        end
        chk("core_rdata", 64'(core_rdata), 64'h0F0F0F0F);
        drive(0, 4'h0, '0, '0, 1, 4'h0, 10'h003, '0, 32'h33333333);
        @(negedge clk);
        chk("starve_accept_cyc", 64'(host_starved), 64'd1);
        idle(1);
        @(negedge clk);
        chk("starve_cleared", 64'(host_starved), 64'd0);
        idle(3);

        // Reset one cycle after a read is accepted: response dropped
        @(posedge clk);
        #1;
        host_req_valid = 1'b1; host_req_we = 4'h0; host_req_addr = 10'h001;
        @(posedge clk);
        #1;
        host_req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_flight_valid", 64'(host_rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);
        @(negedge clk);
        chk("rst_flight_starved", 64'(host_starved), 64'd0);

        idle(3);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001: Parameter ADDR_WIDTH, default 10, BRAM word-address width.
REQ-002: Parameter DWIDTH, default 32, data width (NB_COL=4 bytes of COL_WIDTH=8).
REQ-003: Parameter READ_LATENCY, default 1, legal 1..3; BRAM read latency in cycles.
REQ-004: Parameter STARVE_LIMIT, default 16, legal 1..255; host wait cycles before starvation is flagged.
REQ-005: Ports (clock and reset first):
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- core_en  in  1  core memory-stage access this cycle
- core_we  in  4  core byte write enables
- core_addr  in  ADDR_WIDTH  core word address
- core_wdata  in  DWIDTH  core write data
- core_rdata  out  DWIDTH  read data to core (= mem_rdata)
- host_req_valid  in  1  host request valid
- host_req_ready  out  1  host request accepted when valid&&ready
- host_req_we  in  4  host byte write enables; 0 = read
- host_req_addr  in  ADDR_WIDTH  host word address
- host_req_wdata  in  DWIDTH  host write data
- host_rsp_valid  out  1  host read data valid, one cycle
- host_rsp_rdata  out  DWIDTH  host read data
- host_starved  out  1  host waited >= STARVE_LIMIT cycles
- mem_en  out  1  BRAM port enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  ADDR_WIDTH  BRAM address
- mem_wdata  out  DWIDTH  BRAM write data
- mem_rdata  in  DWIDTH  BRAM read data, READ_LATENCY after mem_en

Function
REQ-006: Core has absolute priority; core is never stalled and sees no added latency.
REQ-007: core_en=1: mem_* = core_* combinationally; host_req_ready=0.
REQ-008: core_en=0: host_req_ready=1; mem_en=host_req_valid, mem_we/addr/wdata = host_req_*; mem_we forced 0 when host_req_valid=0.
REQ-009: host_req_ready depends only on core_en, never on host_req_valid.
REQ-010: core_rdata = mem_rdata unconditionally.
REQ-011: Accepted host read (host_req_we=0) pushes a 1 into a READ_LATENCY-deep tag shift register; all other cycles push 0.
REQ-012: host_rsp_valid = tag register output; asserted exactly READ_LATENCY cycles after acceptance, host_rsp_rdata = mem_rdata that cycle.
REQ-013: Back-to-back host reads accepted on consecutive cycles give responses on consecutive cycles, in order; no response backpressure.
REQ-014: Accepted host writes produce no response.
REQ-015: Wait counter (8 bits): +1 each cycle host_req_valid=1 and host_req_ready=0; saturates at 255; cleared on acceptance or when host_req_valid=0.
REQ-016: host_starved = (wait counter >= STARVE_LIMIT), registered; updates the cycle after the counter changes.
REQ-017: Host read and core write to the same address in one cycle cannot occur (REQ-007); host read after core write returns new data.
REQ-018: host_req_* changing while valid and not ready is tolerated; the value presented in the acceptance cycle is used.

Reset
REQ-019: reset=1 asynchronously clears tag register, wait counter, host_starved, host_rsp_valid to 0.
REQ-020: Host reads in flight when reset asserts are dropped; no host_rsp_valid after reset release.
REQ-021: Combinational outputs (mem_*, host_req_ready, core_rdata) follow REQ-007/008 during reset.

Verification
REQ-022: core_en=0, host read addr 0x005, READ_LATENCY=2, mem holds 0xDEADBEEF -> host_rsp_valid=1 exactly 2 cycles after acceptance, rdata 0xDEADBEEF.
REQ-023: core_en=1 and host_req_valid=1 same cycle, core addr 0x010 -> mem_addr=0x010, host_req_ready=0; host accepted first cycle core_en=0.
REQ-024: core_en=1 for 20 cycles, host valid throughout, STARVE_LIMIT=16 -> host_starved=1 from cycle 17; clears the cycle after acceptance.
REQ-025: Host reads 0x001,0x002,0x003 on consecutive idle cycles -> three consecutive responses, in order, matching contents.
REQ-026: Host write we=4'b0011 data 0x12345678 to 0x020 holding 0xAAAAAAAA, then host read -> rdata 0xAAAA5678, no response for the write.
REQ-027: reset asserted one cycle after host read acceptance (READ_LATENCY=2) -> host_rsp_valid stays 0; wait counter reads 0 after release.
